// File: rtl/sim_result_checker_pkg.sv
// Shared types and widths for the softmax result checker.
package sim_result_checker_pkg;

    localparam int LANE_W = 16;
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sim_result_checker_lane_tol_cmp.sv
// One-lane tolerance comparator: flags |a - b| > TOL on 16-bit signed operands.
module lane_tol_cmp
    import sim_result_checker_pkg::*;
#(
    parameter int TOL = 2
) (
    input  logic signed [LANE_W-1:0] a,
    input  logic signed [LANE_W-1:0] b,
    output logic                     fail
);

    logic signed [LANE_W:0] diff;
    logic        [LANE_W:0] mag;

    // 17-bit difference of two 16-bit signed values is always representable,
    // and so is its magnitude, so no saturation is needed here.
    function automatic logic [LANE_W:0] abs17(input logic signed [LANE_W:0] v);
        return v[LANE_W] ? $unsigned(-v) : $unsigned(v);
    endfunction

    always_comb begin
        diff = {a[LANE_W-1], a} - {b[LANE_W-1], b};
        mag  = abs17(diff);
        fail = (mag > (LANE_W+1)'(TOL));
    end

endmodule

// File: rtl/sim_result_checker.sv
// Result sink for the N-lane softmax datapath: compares each valid beat against
// a cyclic expected-vector memory, counts results/errors and reports done/pass.
module sim_result_checker
    import sim_result_checker_pkg::*;
#(
    parameter int N        = 8,
    parameter int DEPTH    = 3,
    parameter int NUM_VECS = 12,
    parameter int TOL      = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       valid_out,
    input  logic [N*LANE_W-1:0]        out_y_flat,
    input  logic                       exp_we,
    input  logic [$clog2(DEPTH)-1:0]   exp_addr,
    input  logic [N*LANE_W-1:0]        exp_data,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout,
    output logic [CNT_W-1:0]           rx_count,
    output logic [CNT_W-1:0]           err_count,
    output logic [N-1:0]               lane_err_mask,
    output logic [CNT_W-1:0]           first_err_idx
);

    localparam int AW = $clog2(DEPTH);

    logic [N*LANE_W-1:0] exp_mem [DEPTH];
    logic [N*LANE_W-1:0] exp_rd;
    state_t              state, state_nxt;
    logic [AW-1:0]       idx;
    logic [CNT_W-1:0]    idle_cnt;
    logic [N-1:0]        lane_fail_p0;
    logic                beat_p0, vec_fail_p0, last_beat_p0, stall_out_p0, arm_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Expected memory has no reset so its contents survive a mid-run rst.
    always_ff @(posedge clk) begin
        if (exp_we && (int'(exp_addr) < DEPTH))
            exp_mem[exp_addr] <= exp_data;
    end

    assign exp_rd = exp_mem[idx];

    for (genvar i = 0; i < N; i++) begin : g_lane
        lane_tol_cmp #(.TOL(TOL)) u_cmp (
            .a    (out_y_flat[i*LANE_W +: LANE_W]),
            .b    (exp_rd[i*LANE_W +: LANE_W]),
            .fail (lane_fail_p0[i])
        );
    end

    // Stage p0: combinational compare and control decisions on the sampled beat
    always_comb begin
        state_nxt    = state;
        beat_p0      = (state == ST_RUN) && valid_out;
        vec_fail_p0  = |lane_fail_p0;
        last_beat_p0 = beat_p0 && (rx_count == CNT_W'(NUM_VECS - 1));
        stall_out_p0 = (state == ST_RUN) && !valid_out && (idle_cnt == CNT_W'(TIMEOUT - 1));
        arm_p0       = (state != ST_RUN) && start;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_RUN;
            ST_RUN:           if (last_beat_p0 || stall_out_p0) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Stage p1: registered state, counters and compare results
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            rx_count      <= '0;
            err_count     <= '0;
            lane_err_mask <= '0;
            first_err_idx <= CNT_MAX;
            idx           <= '0;
            idle_cnt      <= '0;
            timeout       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (arm_p0) begin
                rx_count      <= '0;
                err_count     <= '0;
                lane_err_mask <= '0;
                first_err_idx <= CNT_MAX;
                idx           <= '0;
                idle_cnt      <= '0;
                timeout       <= 1'b0;
            end else if (beat_p0) begin
                rx_count      <= rx_count + 1'b1;
                lane_err_mask <= lane_fail_p0;
                idle_cnt      <= '0;
                idx           <= (idx == AW'(DEPTH - 1)) ? '0 : idx + 1'b1;
                if (vec_fail_p0) begin
                    err_count <= sat_inc(err_count);
                    if (err_count == '0)
                        first_err_idx <= rx_count;
                end
            end else if (state == ST_RUN) begin
                idle_cnt <= idle_cnt + 1'b1;
                if (stall_out_p0)
                    timeout <= 1'b1;
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign pass = done && !timeout && (err_count == '0);

endmodule

// File: tb/tb_sim_result_checker.sv
// Self-checking bench for sim_result_checker: vector table, directed sequences and random traffic vs a reference model.
module tb_sim_result_checker;

    localparam int N        = 8;
    localparam int DEPTH    = 3;
    localparam int NUM_VECS = 12;
    localparam int TOL      = 2;
    localparam int TIMEOUT  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0, start = 1'b0, valid_out = 1'b0, exp_we = 1'b0;
    logic [N*16-1:0]   out_y_flat = '0, exp_data = '0;
    logic [1:0]        exp_addr = '0;
    logic              busy, done, pass, timeout;
    logic [15:0]       rx_count, err_count, first_err_idx;
    logic [N-1:0]      lane_err_mask;

    always #5 clk = ~clk;

    sim_result_checker #(.N(N), .DEPTH(DEPTH), .NUM_VECS(NUM_VECS), .TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .valid_out(valid_out), .out_y_flat(out_y_flat),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .rx_count(rx_count),
        .err_count(err_count), .lane_err_mask(lane_err_mask), .first_err_idx(first_err_idx)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 running, 2 finished
    int           m_mem [DEPTH][N];
    int           m_phase, m_rx, m_err, m_first, m_idle, m_idx;
    bit           m_to;
    logic [N-1:0] m_mask;

    logic [N*16-1:0] vecs [DEPTH];

    typedef struct {
        logic [15:0] e;
        logic [15:0] a;
        logic [7:0]  mask;
    } row_t;
    row_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic model_clear();
        m_rx = 0; m_err = 0; m_first = 16'hFFFF; m_idle = 0; m_to = 0; m_mask = '0; m_idx = 0;
    endtask

    task automatic model_step();
        int diff;
        logic [N-1:0] fl;
        if (rst) begin
            m_phase = 0;
            model_clear();
        end else if (m_phase != 1) begin
            if (start) begin
                m_phase = 1;
                model_clear();
            end
        end else if (valid_out) begin
            fl = '0;
            for (int i = 0; i < N; i++) begin
                diff = int'($signed(out_y_flat[i*16 +: 16])) - m_mem[m_idx][i];
                if (diff < 0) diff = -diff;
                fl[i] = (diff > TOL);
            end
            m_mask = fl;
            if (fl != '0) begin
                if (m_first == 16'hFFFF) m_first = m_rx;
                if (m_err < 65535) m_err++;
            end
            m_rx++;
            m_idx = (m_idx + 1) % DEPTH;
            m_idle = 0;
            if (m_rx == NUM_VECS) m_phase = 2;
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_phase = 2;
                m_to = 1;
            end
        end
        if (exp_we && exp_addr < DEPTH)
            for (int i = 0; i < N; i++) m_mem[exp_addr][i] = int'($signed(exp_data[i*16 +: 16]));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".busy"},    32'(busy),          32'(m_phase == 1));
        chk({tag, ".done"},    32'(done),          32'(m_phase == 2));
        chk({tag, ".pass"},    32'(pass),          32'(m_phase == 2 && !m_to && m_err == 0));
        chk({tag, ".timeout"}, 32'(timeout),       32'(m_to));
        chk({tag, ".rx"},      32'(rx_count),      32'(m_rx));
        chk({tag, ".err"},     32'(err_count),     32'(m_err));
        chk({tag, ".mask"},    32'(lane_err_mask), 32'(m_mask));
        chk({tag, ".first"},   32'(first_err_idx), 32'(m_first));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".busy"},  32'(busy), 0);
        chk({tag, ".done"},  32'(done), 0);
        chk({tag, ".pass"},  32'(pass), 0);
        chk({tag, ".to"},    32'(timeout), 0);
        chk({tag, ".rx"},    32'(rx_count), 0);
        chk({tag, ".err"},   32'(err_count), 0);
        chk({tag, ".mask"},  32'(lane_err_mask), 0);
        chk({tag, ".first"}, 32'(first_err_idx), 32'hFFFF);
    endtask

    task automatic do_rst();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic load_vec(input int a, input logic [N*16-1:0] v);
        exp_we = 1'b1; exp_addr = 2'(a); exp_data = v; tick(); exp_we = 1'b0;
    endtask

    task automatic send(input logic [N*16-1:0] v, input string tag);
        valid_out = 1'b1; out_y_flat = v; tick(); valid_out = 1'b0;
        check_model(tag);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check_model(tag);
        end
    endtask

    function automatic logic [N*16-1:0] make_vec();
        logic [N*16-1:0] v;
        for (int i = 0; i < N; i++) v[i*16 +: 16] = 16'($urandom_range(0, 32000) - 16000);
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*16-1:0] v;
        int lane;

        tbl[0] = '{16'h7FFF, 16'h8000, 8'h01};
        tbl[1] = '{16'hFFFF, 16'h0001, 8'h00};
        tbl[2] = '{16'h8000, 16'h7FFF, 8'h01};
        tbl[3] = '{16'd100,  16'd103,  8'h01};
        tbl[4] = '{16'd100,  16'd102,  8'h00};
        tbl[5] = '{16'd100,  16'd98,   8'h00};
        tbl[6] = '{16'd100,  16'd97,   8'h01};
        tbl[7] = '{16'h0000, 16'h0000, 8'h00};

        m_phase = 0;
        model_clear();
        for (int a = 0; a < DEPTH; a++) for (int i = 0; i < N; i++) m_mem[a][i] = 0;

        // reset state
        do_rst();
        check_reset_vals("reset");

        // clean 12-beat run, back-to-back
        for (int a = 0; a < DEPTH; a++) begin
            vecs[a] = make_vec();
            load_vec(a, vecs[a]);
        end
        pulse_start();
        chk("run1.busy", 32'(busy), 1);
        for (int b = 0; b < NUM_VECS; b++) begin
            send(vecs[b % DEPTH], "run1");
            if (b == NUM_VECS - 2) chk("run1.done_early", 32'(done), 0);
        end
        chk("run1.done", 32'(done), 1);
        chk("run1.pass", 32'(pass), 1);
        chk("run1.rx", 32'(rx_count), 12);
        chk("run1.err", 32'(err_count), 0);
        chk("run1.first", 32'(first_err_idx), 32'hFFFF);

        // beat 5 lane 3 off by +3, then by +2
        for (int off = 3; off >= 2; off--) begin
            pulse_start();
            chk("err.cleared", 32'(rx_count), 0);
            for (int b = 0; b < NUM_VECS; b++) begin
                v = vecs[b % DEPTH];
                if (b == 4) v[3*16 +: 16] = v[3*16 +: 16] + 16'(off);
                send(v, "err");
                if (b == 4) chk("err.mask_b5", 32'(lane_err_mask), (off == 3) ? 32'h08 : 32'h00);
            end
            chk("err.err", 32'(err_count), (off == 3) ? 1 : 0);
            chk("err.first", 32'(first_err_idx), (off == 3) ? 4 : 32'hFFFF);
            chk("err.pass", 32'(pass), (off == 3) ? 0 : 1);
        end

        // stall timeout, then a beat on the 64th stall cycle
        pulse_start();
        for (int b = 0; b < 5; b++) send(vecs[b % DEPTH], "to");
        idle_cycles(TIMEOUT, "to");
        chk("to.timeout", 32'(timeout), 1);
        chk("to.done", 32'(done), 1);
        chk("to.pass", 32'(pass), 0);
        chk("to.rx", 32'(rx_count), 5);
        pulse_start();
        for (int b = 0; b < 5; b++) send(vecs[b % DEPTH], "nto");
        idle_cycles(TIMEOUT - 1, "nto");
        send(vecs[5 % DEPTH], "nto");
        chk("nto.timeout", 32'(timeout), 0);
        chk("nto.busy", 32'(busy), 1);
        chk("nto.rx", 32'(rx_count), 6);
        idle_cycles(TIMEOUT, "nto");

        // rst mid-run, then clean run from retained memory (start in RUN ignored)
        pulse_start();
        for (int b = 0; b < 6; b++) send(vecs[b % DEPTH], "mid");
        do_rst();
        check_reset_vals("midrst");
        pulse_start();
        for (int b = 0; b < NUM_VECS; b++) begin
            start = (b == 3);
            send(vecs[b % DEPTH], "rerun");
        end
        start = 1'b0;
        chk("rerun.pass", 32'(pass), 1);
        chk("rerun.rx", 32'(rx_count), 12);

        // valid in DONE and IDLE is ignored
        for (int b = 0; b < 3; b++) send(~vecs[b % DEPTH], "vdone");
        chk("vdone.rx", 32'(rx_count), 12);
        chk("vdone.err", 32'(err_count), 0);
        do_rst();
        for (int b = 0; b < 3; b++) send(~vecs[b % DEPTH], "vidle");
        chk("vidle.rx", 32'(rx_count), 0);
        chk("vidle.busy", 32'(busy), 0);

        // lane compare table, lane 0 carries the row's actual value
        for (int r = 0; r < 8; r++) begin
            do_rst();
            v = {N{tbl[r].e}};
            for (int a = 0; a < DEPTH; a++) load_vec(a, v);
            pulse_start();
            v[15:0] = tbl[r].a;
            send(v, "tbl");
            chk($sformatf("tbl[%0d].mask", r), 32'(lane_err_mask), 32'(tbl[r].mask));
        end

        // random traffic against the model
        do_rst();
        for (int a = 0; a < DEPTH; a++) begin
            vecs[a] = make_vec();
            load_vec(a, vecs[a]);
        end
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 19) == 0);
            valid_out = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                lane = m_mem[m_idx][i];
                if ($urandom_range(0, 14) == 0) lane += int'($urandom_range(0, 8)) - 4;
                v[i*16 +: 16] = 16'(lane);
            end
            out_y_flat = v;
            exp_we     = ($urandom_range(0, 24) == 0);
            exp_addr   = 2'($urandom_range(0, 3));
            exp_data   = make_vec();
            tick();
            check_model("rnd");
        end
        rst = 1'b0; start = 1'b0; valid_out = 1'b0; exp_we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
